// File: rtl/camera_scroll_ctrl.sv
// camera_scroll_ctrl -- vertical camera scroller for a block-based playfield.
//
// The character centre is compared against the current camera window once per
// frame. When it leaves the window, the camera moves one block toward it. With
// CAMERA_FADE_EN defined, the move is wrapped in a fade-out / fade-in sequence
// that is paced by frame_start. Without it, the move happens on the cycle after
// the frame in which the crossing is detected.
//
// Config macro: CAMERA_FADE_EN (undefined = no fade; fade_level is tied to 0)
//
// Ports:
//   sys_clk       clock, rising edge
//   sys_rst       synchronous active-high reset
//   frame_start   one-cycle pulse at the start of vertical blank
//   char_abs_y    character absolute y (top edge)
//   cam_set       manual camera load request (accepted only while idle)
//   cam_set_val   camera index to load
//   cam_set_ack   one-cycle pulse when a load is accepted
//   camera_y      current camera index
//   camera_offset camera_y * BLOCK_WIDTH
//   fade_level    screen dim level, 0 = none
//   phys_freeze   physics hold while a transition is in flight
//   busy          high whenever a transition is in progress
module camera_scroll_ctrl #(
    parameter int PHY_WIDTH    = 16,
    parameter int CAMERA_WIDTH = 6,
    parameter int BLOCK_WIDTH  = 480,
    parameter int CHAR_WIDTH_Y = 50,
    parameter int FADE_WIDTH   = 3,
    parameter int FADE_MAX     = 7
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    frame_start,
    input  logic [PHY_WIDTH-1:0]    char_abs_y,
    input  logic                    cam_set,
    input  logic [CAMERA_WIDTH-1:0] cam_set_val,
    output logic                    cam_set_ack,
    output logic [CAMERA_WIDTH-1:0] camera_y,
    output logic [PHY_WIDTH-1:0]    camera_offset,
    output logic [FADE_WIDTH-1:0]   fade_level,
    output logic                    phys_freeze,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, FADE_OUT, SWITCH, FADE_IN} state_t;

    localparam logic [PHY_WIDTH-1:0]    BLK     = PHY_WIDTH'(BLOCK_WIDTH);
    localparam logic [PHY_WIDTH:0]      HALF_CH = (PHY_WIDTH+1)'(CHAR_WIDTH_Y / 2);
    localparam logic [CAMERA_WIDTH-1:0] CAM_TOP = '1;

    state_t                  state, state_nx;
    logic                    dir_up, dir_nx;
    logic [CAMERA_WIDTH-1:0] cam_y_nx;
    logic [PHY_WIDTH-1:0]    off_nx;
    logic [FADE_WIDTH-1:0]   fade_nx;
    logic                    ack_nx;

    // One extra bit so the centre and the window top never wrap.
    logic [PHY_WIDTH:0] cy, win_top;
    logic               go_up, go_down;

    assign cy      = {1'b0, char_abs_y} + HALF_CH;
    assign win_top = {1'b0, camera_offset} + {1'b0, BLK};
    assign go_up   = (cy >= win_top) && (camera_y != CAM_TOP);
    assign go_down = (cy < {1'b0, camera_offset}) && (camera_y != '0);

    always_comb begin
        state_nx = state;
        dir_nx   = dir_up;
        cam_y_nx = camera_y;
        off_nx   = camera_offset;
        fade_nx  = fade_level;
        ack_nx   = 1'b0;
        case (state)
            IDLE: begin
                // A load takes precedence and suppresses this frame's crossing test.
                if (cam_set) begin
                    cam_y_nx = cam_set_val;
                    off_nx   = PHY_WIDTH'(cam_set_val) * BLK;
                    ack_nx   = 1'b1;
                end else if (frame_start && (go_up || go_down)) begin
                    dir_nx = go_up;
`ifdef CAMERA_FADE_EN
                    state_nx = FADE_OUT;
`else
                    state_nx = SWITCH;
`endif
                end
            end
`ifdef CAMERA_FADE_EN
            FADE_OUT: begin
                if (frame_start) begin
                    if (fade_level == FADE_WIDTH'(FADE_MAX)) state_nx = SWITCH;
                    else                                     fade_nx  = fade_level + 1'b1;
                end
            end
            FADE_IN: begin
                if (frame_start) begin
                    if (fade_level == '0) state_nx = IDLE;
                    else                  fade_nx  = fade_level - 1'b1;
                end
            end
`endif
            SWITCH: begin
                // Saturation was already checked when the transition started,
                // so the step below never crosses a bound.
                if (dir_up) begin
                    cam_y_nx = camera_y + 1'b1;
                    off_nx   = camera_offset + BLK;
                end else begin
                    cam_y_nx = camera_y - 1'b1;
                    off_nx   = camera_offset - BLK;
                end
`ifdef CAMERA_FADE_EN
                state_nx = FADE_IN;
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so that they line up
    // with the state register. In the no-fade build, SWITCH is the only
    // non-idle state, so phys_freeze is high only for that cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= IDLE;
            dir_up        <= 1'b1;
            camera_y      <= '0;
            camera_offset <= '0;
            cam_set_ack   <= 1'b0;
            phys_freeze   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nx;
            dir_up        <= dir_nx;
            camera_y      <= cam_y_nx;
            camera_offset <= off_nx;
            cam_set_ack   <= ack_nx;
            phys_freeze   <= (state_nx != IDLE);
            busy          <= (state_nx != IDLE);
        end
    end

`ifdef CAMERA_FADE_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) fade_level <= '0;
        else         fade_level <= fade_nx;
    end
`else
    assign fade_level = '0;
    logic unused_fade;
    assign unused_fade = ^fade_nx;
`endif

endmodule
